// File: rtl/drive_pkg.sv
// drive_pkg: shared types for the differential-drive controller.
//   state_e      : escape FSM states
//   motion_e     : logical robot motion commands
//   wheel_e      : per-wheel servo direction
//   wheel_pair_t : left/right wheel directions for one motion
//   motion_to_wheels() : logical motion -> per-wheel direction mapping
package drive_pkg;

    typedef enum logic [1:0] {
        DRIVE,
        ESC_BACK,
        ESC_TURN
    } state_e;

    typedef enum logic [2:0] {
        M_STOP,
        M_FWD,
        M_REV,
        M_LEFT,
        M_RIGHT
    } motion_e;

    typedef enum logic [1:0] {
        W_S,
        W_F,
        W_R
    } wheel_e;

    typedef struct packed {
        wheel_e l;
        wheel_e r;
    } wheel_pair_t;

    // Turning is done in place: one wheel forward, the other reverse.
    function automatic wheel_pair_t motion_to_wheels(motion_e m);
        wheel_pair_t w;
        w.l = W_S;
        w.r = W_S;
        case (m)
            M_FWD:   begin w.l = W_F; w.r = W_F; end
            M_REV:   begin w.l = W_R; w.r = W_R; end
            M_LEFT:  begin w.l = W_R; w.r = W_F; end
            M_RIGHT: begin w.l = W_F; w.r = W_R; end
            default: begin w.l = W_S; w.r = W_S; end
        endcase
        return w;
    endfunction

endpackage

// File: rtl/servo_pwm_ch.sv
// servo_pwm_ch: one servo PWM channel driven from a shared frame counter.
//   clk_i     : system clock
//   rst_ni    : asynchronous active-low reset
//   per_cnt_i : shared frame position counter
//   wrap_i    : high on the last cycle of a frame
//   width_i   : requested pulse width (cycles), sampled only at wrap_i
//   pwm_o     : registered servo pulse
module servo_pwm_ch #(
    parameter int unsigned CNT_W  = 20,
    parameter int unsigned PW_RST = 75000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [CNT_W-1:0] per_cnt_i,
    input  logic             wrap_i,
    input  logic [CNT_W-1:0] width_i,
    output logic             pwm_o
);

    logic [CNT_W-1:0] width_q, width_d;
    logic             pwm_q, pwm_d;

    // Width only changes at the frame boundary, so a frame never gets a
    // truncated or stretched pulse.
    always_comb begin
        width_d = wrap_i ? width_i : width_q;
        pwm_d   = (per_cnt_i < width_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            width_q <= CNT_W'(PW_RST);
            pwm_q   <= 1'b0;
        end else begin
            width_q <= width_d;
            pwm_q   <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/diff_drive_ctrl.sv
// diff_drive_ctrl: two-wheel differential-drive controller with obstacle
// escape (reverse, then turn) and per-wheel servo PWM generation.
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   turn_left  : left-turn request (level, highest priority)
//   forward    : forward request (level)
//   turn_right : right-turn request (level, lowest priority)
//   too_close  : obstacle flag (level), starts/extends the escape sequence
//   pwm_l      : left servo pulse
//   pwm_r      : right servo pulse
//   escaping   : high while an escape sequence is running
//   esc_count  : escapes started from DRIVE, saturating at 255
module diff_drive_ctrl
    import drive_pkg::*;
#(
    parameter int unsigned PERIOD_CYC = 1000000,
    parameter int unsigned PW_STOP    = 75000,
    parameter int unsigned PW_FWD     = 100000,
    parameter int unsigned PW_REV     = 50000,
    parameter int unsigned BACK_CYC   = 600000,
    parameter int unsigned TURN_CYC   = 600000,
    parameter int unsigned MIRROR_R   = 1,
    parameter int unsigned ESC_DIR    = 0,
    parameter int unsigned ESC_ALT    = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       turn_left,
    input  logic       forward,
    input  logic       turn_right,
    input  logic       too_close,
    output logic       pwm_l,
    output logic       pwm_r,
    output logic       escaping,
    output logic [7:0] esc_count
);

    localparam int unsigned CNT_W = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
    localparam int unsigned TMAX  = (BACK_CYC > TURN_CYC) ? BACK_CYC : TURN_CYC;
    localparam int unsigned TMR_W = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(PERIOD_CYC - 1);
    localparam logic [TMR_W-1:0] BACK_LAST = TMR_W'(BACK_CYC - 1);
    localparam logic [TMR_W-1:0] TURN_LAST = TMR_W'(TURN_CYC - 1);
    localparam logic [CNT_W-1:0] W_STOP    = CNT_W'(PW_STOP);
    localparam logic [CNT_W-1:0] W_FWD     = CNT_W'(PW_FWD);
    localparam logic [CNT_W-1:0] W_REV     = CNT_W'(PW_REV);

    if (PW_STOP >= PERIOD_CYC || PW_FWD >= PERIOD_CYC || PW_REV >= PERIOD_CYC) begin : g_bad_pw
        $error("diff_drive_ctrl: every PW_* must be smaller than PERIOD_CYC");
    end
    if (BACK_CYC < 1 || TURN_CYC < 1) begin : g_bad_phase
        $error("diff_drive_ctrl: BACK_CYC and TURN_CYC must be at least 1");
    end

    // ------------------------------------------------------------------
    // Shared frame counter
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
    logic             wrap;

    always_comb begin
        wrap      = (per_cnt_q == LAST_CNT);
        per_cnt_d = wrap ? '0 : per_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt_q <= '0;
        end else begin
            per_cnt_q <= per_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Escape FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [7:0]       esc_cnt_q, esc_cnt_d;
    logic             dir_q, dir_d;     // 0 = escape turns left, 1 = right
    motion_e          motion;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= DRIVE;
            timer_q   <= '0;
            esc_cnt_q <= '0;
            dir_q     <= (ESC_DIR != 0);
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            esc_cnt_q <= esc_cnt_d;
            dir_q     <= dir_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        esc_cnt_d = esc_cnt_q;
        dir_d     = dir_q;
        case (state_q)
            DRIVE: begin
                if (too_close) begin
                    state_d = ESC_BACK;
                    timer_d = '0;
                    if (esc_cnt_q != '1) begin
                        esc_cnt_d = esc_cnt_q + 8'd1;
                    end
                end
            end
            ESC_BACK: begin
                // Timer parks at its last value so a held obstacle simply
                // extends reversing until the flag clears.
                if (timer_q == BACK_LAST) begin
                    if (!too_close) begin
                        state_d = ESC_TURN;
                        timer_d = '0;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ESC_TURN: begin
                if (too_close) begin
                    state_d = ESC_BACK;
                    timer_d = '0;
                end else if (timer_q == TURN_LAST) begin
                    state_d = DRIVE;
                    timer_d = '0;
                    if (ESC_ALT != 0) begin
                        dir_d = ~dir_q;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = DRIVE;
                timer_d = '0;
            end
        endcase
    end

    always_comb begin
        motion   = M_STOP;
        escaping = (state_q != DRIVE);
        case (state_q)
            DRIVE: begin
                if (turn_left) begin
                    motion = M_LEFT;
                end else if (forward) begin
                    motion = M_FWD;
                end else if (turn_right) begin
                    motion = M_RIGHT;
                end else begin
                    motion = M_STOP;
                end
            end
            ESC_BACK: motion = M_REV;
            ESC_TURN: motion = dir_q ? M_RIGHT : M_LEFT;
            default:  motion = M_STOP;
        endcase
    end

    assign esc_count = esc_cnt_q;

    // ------------------------------------------------------------------
    // Wheel mapping and PWM channels
    // ------------------------------------------------------------------
    function automatic logic [CNT_W-1:0] wheel_width(wheel_e w, logic mirror);
        case (w)
            W_F:     return mirror ? W_REV : W_FWD;
            W_R:     return mirror ? W_FWD : W_REV;
            default: return W_STOP;
        endcase
    endfunction

    wheel_pair_t      wheels;
    logic [CNT_W-1:0] width_l, width_r;

    always_comb begin
        wheels  = motion_to_wheels(motion);
        width_l = wheel_width(wheels.l, 1'b0);
        width_r = wheel_width(wheels.r, MIRROR_R != 0);
    end

    servo_pwm_ch #(
        .CNT_W  (CNT_W),
        .PW_RST (PW_STOP)
    ) u_ch_l (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .per_cnt_i (per_cnt_q),
        .wrap_i    (wrap),
        .width_i   (width_l),
        .pwm_o     (pwm_l)
    );

    servo_pwm_ch #(
        .CNT_W  (CNT_W),
        .PW_RST (PW_STOP)
    ) u_ch_r (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .per_cnt_i (per_cnt_q),
        .wrap_i    (wrap),
        .width_i   (width_r),
        .pwm_o     (pwm_r)
    );

endmodule

// File: doc/diff_drive_ctrl.md
Name: diff_drive_ctrl

Overview:
Parametrised two-wheel differential-drive controller for the continuous-rotation servo robot. It arbitrates level-sensitive motion requests (left/forward/right) and runs a two-phase obstacle-escape sequence (reverse, then turn) on too_close. It generates glitch-free servo PWM per wheel from one shared period counter. It sits between the sensor/decision logic and the wheel servo pins.

Parameters:
PERIOD_CYC, 1000000, servo frame length in clk cycles (20 ms @ 50 MHz)
PW_STOP, 75000, neutral pulse width (cycles)
PW_FWD, 100000, forward pulse width (cycles)
PW_REV, 50000, reverse pulse width (cycles)
BACK_CYC, 600000, minimum reverse-phase length (cycles, >=1)
TURN_CYC, 600000, turn-phase length (cycles, >=1)
MIRROR_R, 1, 1 = right servo mounted mirrored: its FWD and REV widths are swapped
ESC_DIR, 0, escape turn direction: 0 = left, 1 = right
ESC_ALT, 0, 1 = escape turn direction alternates on each new escape, starting at ESC_DIR

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock; asynchronous, active-low
turn_left  in  1  left-turn request (level, synchronous to clk)
forward  in  1  forward request (level)
turn_right  in  1  right-turn request (level)
too_close  in  1  obstacle flag (level)
pwm_l  out  1  left servo pulse
pwm_r  out  1  right servo pulse
escaping  out  1  high while state != DRIVE
esc_count  out  8  escapes started from DRIVE, saturating at 255

Behaviour:
- Reset (async assert): pwm_l=0, pwm_r=0, escaping=0, esc_count=0, state=DRIVE, timer=0, per_cnt=0, latched widths=PW_STOP, alternate-direction flag=ESC_DIR.
- States: DRIVE, ESC_BACK, ESC_TURN.
- DRIVE: too_close=1 -> ESC_BACK next edge; timer=0; esc_count+1 (saturating).
- DRIVE, otherwise: motion follows request priority turn_left > forward > turn_right; no request -> STOP.
- ESC_BACK: motion=REV; timer increments and saturates at BACK_CYC-1.
  - Exit to ESC_TURN on the first cycle with timer==BACK_CYC-1 and too_close==0; timer=0 on exit.
  - too_close held high therefore extends the phase indefinitely.
- ESC_TURN: motion=LEFT or RIGHT per the current direction flag; timer increments.
  - too_close=1 -> ESC_BACK; timer=0; esc_count unchanged.
  - Otherwise at timer==TURN_CYC-1 -> DRIVE.
  - On entry to DRIVE with ESC_ALT=1, the direction flag toggles.
- Phase durations: ESC_BACK lasts >= BACK_CYC cycles; ESC_TURN lasts exactly TURN_CYC cycles if uninterrupted.
- Wheel mapping (logical direction L/R):
  - STOP: S/S
  - FWD: F/F
  - REV: R/R
  - LEFT: R/F
  - RIGHT: F/R
- Pulse widths: F=PW_FWD, R=PW_REV, S=PW_STOP. For the right wheel with MIRROR_R=1, F and R widths are swapped.
- per_cnt: counts 0..PERIOD_CYC-1, then wraps to 0.
- Width latch: each channel latches its target width only on the cycle per_cnt==PERIOD_CYC-1, so a new width takes effect from the next frame. No mid-frame width change; no runt pulses.
- PWM output: registered; pwm_x <= (per_cnt < width_x). The first high cycle is the first edge after rst_n deasserts.
- Short phases: motion shorter than one frame may never appear on the pins. This is accepted.
- Widths: per_cnt and timer are $clog2 of their maxima. Elaboration-time check: all PW_* < PERIOD_CYC.

Decomposition:
- Package drive_pkg holds:
  - state enum (DRIVE, ESC_BACK, ESC_TURN)
  - motion enum (M_STOP, M_FWD, M_REV, M_LEFT, M_RIGHT)
  - wheel-direction enum (W_S, W_F, W_R)
  - the motion-to-wheel mapping function
- Sub-module servo_pwm_ch: one channel; inputs per_cnt, wrap strobe, target width; owns the width latch and the registered compare. Instantiated twice.
- Top owns the FSM, timer, per_cnt and esc_count.

Test Plan:
Test params: PERIOD_CYC=100, PW_STOP=15, PW_FWD=20, PW_REV=10, BACK_CYC=8, TURN_CYC=6, MIRROR_R=1, ESC_DIR=0, ESC_ALT=1.
1. Reset then no requests -> outputs 0 during reset; every frame pwm_l and pwm_r high 15 cycles; escaping=0.
2. forward=1 asserted mid-frame -> unchanged until frame end; next frame pwm_l high 20, pwm_r high 10.
3. turn_left=forward=turn_right=1 -> LEFT wins: pwm_l 10, pwm_r 10. Drop turn_left -> next frame FWD (20/10). Drop forward -> RIGHT (20/20).
4. Single-cycle too_close in DRIVE -> escaping high exactly 14 cycles (8 back + 6 left) and esc_count=1. A second pulse later -> turn phase is RIGHT and esc_count=2.
5. too_close high for 20 cycles -> ESC_TURN entered on the cycle after too_close falls. Re-assert too_close during ESC_TURN -> back to ESC_BACK with esc_count unchanged.
6. rst_n low mid-ESC_TURN -> immediately pwm_l=pwm_r=0, escaping=0, esc_count=0. After release -> DRIVE with STOP widths.
